// File: rtl/hack_pkg.sv
// hack_pkg: shared decoded-entry type, Hack field positions and the instruction decoder
package hack_pkg;
  localparam int MAX_DW = 32;
  localparam int A_BIT = 12;
  localparam int C_MSB = 11;
  localparam int C_LSB = 6;
  localparam int D_MSB = 5;
  localparam int J_MSB = 2;
  localparam int DC_LSB = 13;
  typedef struct packed {
    logic              typ;
    logic              illegal;
    logic              a;
    logic [5:0]        c;
    logic [2:0]        d;
    logic [2:0]        j;
    logic [MAX_DW-1:0] v;
  } decoded_t;
  function automatic decoded_t decode_instr(input logic [MAX_DW-1:0] instr, input int dw, input logic strict);
    decoded_t r;
    logic dc_ok;
    r = '0;
    dc_ok = 1'b1;
    for (int i = DC_LSB; i < MAX_DW - 1; i++) dc_ok = (i <= dw - 2 && !instr[i]) ? 1'b0 : dc_ok;
    for (int i = 0; i < MAX_DW; i++) r.v[i] = !instr[dw-1] && i < dw - 1 && instr[i];
    r.typ = instr[dw-1];
    r.illegal = r.typ && strict && !dc_ok;
    r.a = r.typ && instr[A_BIT];
    r.c = r.typ ? instr[C_MSB:C_LSB] : '0;
    r.d = (r.typ && !r.illegal) ? instr[D_MSB-:3] : '0;
    r.j = (r.typ && !r.illegal) ? instr[J_MSB:0] : '0;
    return r;
  endfunction
endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: raw-instruction input and decoded-entry output handshakes
interface instr_decode_stage_if #(parameter int DW = 16);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic          out_valid;
  logic          out_ready;
  logic          out_type;
  logic [DW-1:0] out_v;
  logic          out_a;
  logic [5:0]    out_c;
  logic [2:0]    out_d;
  logic [2:0]    out_j;
  logic          out_illegal;
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_type, out_v, out_a, out_c, out_d, out_j, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_type, out_v, out_a, out_c, out_d, out_j, out_illegal
  );
endinterface

// File: rtl/dec_fifo.sv
// dec_fifo: generic synchronous FIFO with occupancy, full and empty flags
module dec_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  T                             wdata,
  output T                             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  // storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  // pointers wrap modulo DEPTH since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
  // flags and head entry
  always_comb begin
    full = level == LW'(DEPTH);
    empty = level == '0;
    rdata = mem[rp];
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: buffered Hack decoder with strict illegal detection and statistics
module instr_decode_stage import hack_pkg::*; #(
  parameter int DW = 16,
  parameter int DEPTH = 2,
  parameter int STRICT = 1,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_stats,
  instr_decode_stage_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic [CNT_W-1:0]            a_cnt,
  output logic [CNT_W-1:0]            c_cnt,
  output logic [CNT_W-1:0]            ill_cnt
);
  decoded_t din, head;
  logic full, empty, push, pop;
  logic [MAX_DW-1:0] unused_v;
  // decode on the input side so the FIFO holds ready-to-use entries
  always_comb begin
    din = decode_instr(MAX_DW'(bus.in_instr), DW, STRICT != 0);
    push = bus.in_valid && !full;
    pop = !empty && bus.out_ready;
  end
  dec_fifo #(.T(decoded_t), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .wdata(din),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  // outputs forced to zero whenever nothing is presented
  always_comb begin
    bus.in_ready = !full;
    bus.out_valid = !empty;
    bus.out_type = !empty && head.typ;
    bus.out_illegal = !empty && head.illegal;
    bus.out_a = !empty && head.a;
    bus.out_c = empty ? '0 : head.c;
    bus.out_d = empty ? '0 : head.d;
    bus.out_j = empty ? '0 : head.j;
    bus.out_v = empty ? '0 : head.v[DW-1:0];
    unused_v = head.v;
  end
  // saturating per-class counters, clear wins over an accepted push
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_cnt <= '0;
      c_cnt <= '0;
      ill_cnt <= '0;
    end else if (clr_stats) begin
      a_cnt <= '0;
      c_cnt <= '0;
      ill_cnt <= '0;
    end else if (push) begin
      a_cnt <= a_cnt + CNT_W'(!din.typ && a_cnt != '1);
      c_cnt <= c_cnt + CNT_W'(din.typ && !din.illegal && c_cnt != '1);
      ill_cnt <= ill_cnt + CNT_W'(din.illegal && ill_cnt != '1);
    end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
Registered, buffered successor to the combinational Hack instruction decoder. It accepts raw instructions over a valid/ready handshake and decodes them into A/C fields. Decoded entries are stored in a DEPTH-entry FIFO and presented downstream over a second valid/ready handshake. The block also adds strict-mode illegal-instruction detection and saturating per-type statistics counters. It sits between instruction fetch (ROM) and the CPU execute/ALU control.

Parameters:
DW, 16, instruction width; must be >= 16; C-instruction don't-care field is bits DW-2:13
DEPTH, 2, FIFO entries; power of two, >= 2
STRICT, 1, 1 = flag a C-instruction as illegal unless all don't-care bits are 1; 0 = never flag
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr_stats  in  1  synchronous clear of the statistics counters
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept an instruction (= FIFO not full)
in_instr  in  DW  raw instruction
out_valid  out  1  decoded entry available (= FIFO not empty)
out_ready  in  1  downstream accepts the head entry
out_type  out  1  0 = A-instruction, 1 = C-instruction
out_v  out  DW  A-instruction value, zero-extended
out_a  out  1  a bit (A/M select)
out_c  out  6  comp bits c1..c6, c1 is MSB
out_d  out  3  dest bits d1..d3, d1 is MSB
out_j  out  3  jump bits j1..j3, j1 is MSB
out_illegal  out  1  head entry is an illegal C-instruction
level  out  $clog2(DEPTH+1)  FIFO occupancy
a_cnt  out  CNT_W  accepted A-instructions
c_cnt  out  CNT_W  accepted legal C-instructions
ill_cnt  out  CNT_W  accepted illegal C-instructions

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, level = 0, all counters 0, out_valid = 0, all out_* = 0. in_ready = 1 while in reset (combinational, not full); in_valid is ignored because flops are held.
- Push condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- Decoding happens on the input side; the FIFO stores decoded entries, not raw words.
- A-instruction (in_instr[DW-1] = 0): type = 0; v = {1'b0, in_instr[DW-2:0]}; a, c, d, j = 0; illegal = 0.
- C-instruction (in_instr[DW-1] = 1): type = 1; v = 0; a = [12]; c = [11:6]; d = [5:3]; j = [2:0].
- Illegal: STRICT = 1 and any bit of in_instr[DW-2:13] is 0. An illegal entry keeps a and c, forces d = 000 and j = 000 (no side effects), and sets illegal = 1.
- Latency: an instruction pushed in cycle n gives out_valid = 1 at cycle n+1 when the FIFO was empty. There is no input-to-output combinational path.
- in_ready depends only on registered state, never on out_ready. When full, the block does not push even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full and not empty: level is unchanged and order is preserved.
- out_* are zero whenever out_valid = 0. The head entry is held stable while out_valid && !out_ready.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Counters increment on push according to the entry's class and saturate at all ones (no wrap).
- clr_stats takes priority: in a cycle with clr_stats = 1 and a push, the counter becomes 0.
- Reset asserted mid-stream discards all entries immediately.

Decomposition:
- hack_pkg (shared): typedef struct packed decoded_t {type, illegal, a, c[5:0], d[2:0], j[2:0], v}.
- hack_pkg also holds localparams for field positions (A_BIT = 12, C_MSB = 11, C_LSB = 6, D_MSB = 5, J_MSB = 2, DC_LSB = 13) and the function decode_instr(DW, STRICT).
- One sub-module: dec_fifo, a generic synchronous FIFO parameterised on element type and DEPTH, with full, empty and level outputs.
- Decode logic and counters stay in instr_decode_stage.

Test Plan:
1. Reset, then push 16'h7FFF with out_ready = 1 → next cycle out_valid = 1, out_type = 0, out_v = 16'h7FFF, other fields 0; a_cnt = 1.
2. Push 16'hEFD0, 16'hE090, 16'hEDC8 back-to-back with out_ready = 1 → in order: c/d/j = 111111/010/000, 000010/010/000, 110111/001/000, all out_a = 0; c_cnt = 3.
3. out_ready = 0, push 3 instructions with DEPTH = 2 → in_ready = 0 after 2 pushes, level = 2, third accepted only after one pop; head held stable.
4. STRICT = 1, push 16'hAFD0 → out_illegal = 1, out_c = 111111, out_d = 000, out_j = 000; ill_cnt = 1, c_cnt unchanged. With STRICT = 0 → out_illegal = 0, out_d = 010.
5. CNT_W = 4, push 20 A-instructions → a_cnt saturates at 15. clr_stats asserted with a push in the same cycle → a_cnt = 0.
6. Assert rst_n low with level = 2, mid-handshake → out_valid = 0, level = 0, counters 0 immediately; after release, push 16'h0000 → out_v = 0, out_type = 0.
